// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline controller: stage indices,
// exception codes and the flush-sequencer state encoding.
package pipe_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVAL   = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_stall_encode.sv
// Priority-to-thermometer encoder: the highest requesting stage and every
// stage below it are stalled.
module pipe_stall_encode #(
  parameter int NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] stallreq_i,
  output logic [NSTAGE-1:0] therm_o
);

  logic acc_s;

  // Running OR from the top stage downwards yields the thermometer mask.
  always_comb begin
    acc_s   = 1'b0;
    therm_o = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      acc_s      = acc_s | stallreq_i[j];
      therm_o[j] = acc_s;
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline controller: stall mask, exception flush sequencing, stall watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_n
  import pipe_pkg::*;
#(
  parameter int                NSTAGE       = 6,
  parameter int                ADDR_W       = 32,
  parameter int                EXC_W        = 32,
  parameter int                FLUSH_CYCLES = 1,
  parameter logic [ADDR_W-1:0] VEC_OFF      = ADDR_W'(32'h20),
  parameter int                WDOG_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              ext_hold_i,
  input  logic [EXC_W-1:0]  excepttype_i,
  input  logic [ADDR_W-1:0] cp0_epc_i,
  input  logic [ADDR_W-1:0] cp0_ebase_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              hang_o,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WC_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

  pipe_state_e       state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              hang_q, hang_d;

  logic [NSTAGE-1:0] therm_s;
  logic [NSTAGE-1:0] stall_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] new_pc_s;
  logic              flush_s;
  logic              exc_take_s;

  pipe_stall_encode #(.NSTAGE(NSTAGE)) u_enc (
    .stallreq_i (stallreq_i),
    .therm_o    (therm_s)
  );

  assign target_s = (excepttype_i == EXC_W'(EXC_ERET)) ? cp0_epc_i : cp0_ebase_i + VEC_OFF;

  // Flush sequencer: accepts an exception in RUN, holds the target through FLUSH.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_d       = pc_q;
    flush_s    = 1'b0;
    new_pc_s   = '0;
    exc_take_s = 1'b0;
    case (state_q)
      RUN: begin
        if (excepttype_i != '0) begin
          exc_take_s = 1'b1;
          flush_s    = 1'b1;
          new_pc_s   = target_s;
          pc_d       = target_s;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // Exception inputs here come from squashed instructions and are ignored.
        flush_s  = 1'b1;
        new_pc_s = pc_q;
        fcnt_d   = fcnt_q - FC_W'(1);
        if (fcnt_q == FC_W'(1)) begin
          state_d = RUN;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall mask priority: reset, flush, external hold, stage requests.
  always_comb begin
    if (rst || flush_s) begin
      stall_s = '0;
    end else if (ext_hold_i) begin
      stall_s = '1;
    end else begin
      stall_s = therm_s;
    end
  end

  // Watchdog counts consecutive stalled cycles and latches a sticky hang flag.
  always_comb begin
    if (WDOG_CYCLES == 0) begin
      wcnt_d = '0;
      hang_d = 1'b0;
    end else begin
      if (flush_s || (stall_s == '0)) begin
        wcnt_d = '0;
      end else if (wcnt_q == WC_W'(WDOG_CYCLES)) begin
        wcnt_d = wcnt_q;
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
      end
      hang_d = hang_q | (wcnt_d == WC_W'(WDOG_CYCLES));
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= '0;
      wcnt_q  <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      wcnt_q  <= wcnt_d;
      hang_q  <= hang_d;
    end
  end

  assign stall_o  = stall_s;
  assign flush_o  = flush_s & ~rst;
  assign new_pc_o = rst ? '0 : new_pc_s;
  assign hang_o   = hang_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating counters: stalled cycles and accepted exceptions.
  always_comb begin
    if ((stall_s != '0) && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (exc_take_s && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`else
  assign perf_stall_cnt_o = 32'h0;
  assign perf_flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed scenarios plus randomized traffic against a
// cycle-level reference model; two instances cover multi- and single-cycle flush.
module tb_pipe_ctrl_n;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stallreq = 6'h0;
  logic        hold = 1'b0;
  logic [31:0] exc = 32'h0;
  logic [31:0] epc = 32'h0;
  logic [31:0] ebase = 32'h0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, hang_a, hang_b;
  logic [31:0] pc_a, pc_b, ps_a, ps_b, pf_a, pf_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_n #(.NSTAGE(6), .FLUSH_CYCLES(3), .WDOG_CYCLES(8)) u_a (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .ext_hold_i(hold), .excepttype_i(exc),
    .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall_o(stall_a), .flush_o(flush_a),
    .new_pc_o(pc_a), .hang_o(hang_a), .perf_stall_cnt_o(ps_a), .perf_flush_cnt_o(pf_a));

  pipe_ctrl_n #(.NSTAGE(6), .FLUSH_CYCLES(1), .WDOG_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .ext_hold_i(hold), .excepttype_i(exc),
    .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall_o(stall_b), .flush_o(flush_b),
    .new_pc_o(pc_b), .hang_o(hang_b), .perf_stall_cnt_o(ps_b), .perf_flush_cnt_o(pf_b));

  // Thermometer of the highest requesting stage, by arithmetic.
  function automatic logic [5:0] therm(input logic [5:0] r);
    int k = -1;
    for (int j = 0; j < 6; j++) if (r[j]) k = j;
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stallreq = 6'h0; hold = 1'b0; exc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stallreq = 6'h3f; hold = 1'b1; exc = EXC_SYSCALL; ebase = 32'h8000_0000;
    #1;
    n_tests++;
    if (stall_a !== 6'h0 || flush_a !== 1'b0 || pc_a !== 32'h0 || hang_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_a: stall=%h flush=%b pc=%h hang=%b want all 0", stall_a, flush_a, pc_a, hang_a);
    end
    n_tests++;
    if (ps_a !== 32'h0 || pf_a !== 32'h0 || stall_b !== 6'h0 || flush_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_perf_b: ps=%h pf=%h stall_b=%h flush_b=%b want 0", ps_a, pf_a, stall_b, flush_b);
    end
    do_reset();
  endtask

  task automatic test_stall_encode();
    logic [5:0] req_v [5] = '{6'b001000, 6'b001100, 6'b000001, 6'b100000, 6'b000000};
    logic [5:0] exp_v [5] = '{6'b001111, 6'b001111, 6'b000001, 6'b111111, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); stallreq = req_v[i]; hold = 1'b0; #1;
      n_tests++;
      if (stall_a !== exp_v[i]) begin
        n_fail++; $display("FAIL enc_%0d: got %b want %b", i, stall_a, exp_v[i]);
      end
    end
    @(negedge clk); stallreq = 6'b000010; hold = 1'b1; #1;
    n_tests++;
    if (stall_a !== 6'b111111) begin
      n_fail++; $display("FAIL ext_hold: got %b want 111111", stall_a);
    end
    @(negedge clk); stallreq = 6'h0; hold = 1'b0;
  endtask

  task automatic test_exception();
    @(negedge clk);
    ebase = 32'h8000_0000; exc = EXC_SYSCALL; stallreq = 6'h3f; hold = 1'b1; #1;
    n_tests++;
    if (flush_b !== 1'b1 || pc_b !== 32'h8000_0020 || stall_b !== 6'h0) begin
      n_fail++; $display("FAIL exc_single: flush=%b pc=%h stall=%b want 1 80000020 0", flush_b, pc_b, stall_b);
    end
    @(negedge clk); exc = 32'h0; stallreq = 6'h0; hold = 1'b0; #1;
    n_tests++;
    if (flush_b !== 1'b0) begin
      n_fail++; $display("FAIL exc_single_end: flush=%b want 0", flush_b);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush_seq();
    logic [31:0] exc_v [7] = '{32'he, 32'hc, 32'h0, 32'hc, 32'h0, 32'h0, 32'h0};
    logic        fl_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] pc_v  [7] = '{32'h1234, 32'h1234, 32'h1234, 32'h8000_0020,
                               32'h8000_0020, 32'h8000_0020, 32'h0};
    epc = 32'h0000_1234; ebase = 32'h8000_0000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); exc = exc_v[c]; stallreq = (c == 1) ? 6'h08 : 6'h00; #1;
      n_tests++;
      if (flush_a !== fl_v[c] || (fl_v[c] && pc_a !== pc_v[c]) || stall_a !== 6'h0) begin
        n_fail++; $display("FAIL flush_seq_c%0d: flush=%b pc=%h stall=%b want %b %h 0",
                           c + 1, flush_a, pc_a, stall_a, fl_v[c], pc_v[c]);
      end
    end
    exc = 32'h0;
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      stallreq = (c <= 8) ? 6'b001000 : 6'b000000; #1;
      n_tests++;
      if (hang_a !== (c >= 9)) begin
        n_fail++; $display("FAIL wdog_c%0d: hang=%b want %b", c, hang_a, (c >= 9));
      end
      @(negedge clk);
    end
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      stallreq = (c == 5 || c == 10) ? 6'b000000 : 6'b001000; #1;
      n_tests++;
      if (hang_a !== 1'b0) begin
        n_fail++; $display("FAIL wdog_gap_c%0d: hang=%b want 0", c, hang_a);
      end
      @(negedge clk);
    end
    stallreq = 6'h0;
  endtask

  task automatic test_async_reset();
    do_reset();
    epc = 32'h0000_1234; ebase = 32'h8000_0000;
    exc = EXC_ERET;
    @(negedge clk); exc = 32'h0; stallreq = 6'b001000; hold = 1'b1; #1;
    n_tests++;
    if (flush_a !== 1'b1 || pc_a !== 32'h1234) begin
      n_fail++; $display("FAIL arst_pre: flush=%b pc=%h want 1 00001234", flush_a, pc_a);
    end
    #2 rst = 1'b1; #1;
    n_tests++;
    if (stall_a !== 6'h0 || flush_a !== 1'b0 || pc_a !== 32'h0 || hang_a !== 1'b0) begin
      n_fail++; $display("FAIL arst_mid: stall=%b flush=%b pc=%h hang=%b want 0", stall_a, flush_a, pc_a, hang_a);
    end
    @(negedge clk); rst = 1'b0; stallreq = 6'h0; hold = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (flush_a !== 1'b0 || stall_a !== 6'h0) begin
      n_fail++; $display("FAIL arst_run: flush=%b stall=%b want 0 0", flush_a, stall_a);
    end
    @(negedge clk); exc = EXC_OV; #1;
    n_tests++;
    if (flush_a !== 1'b1 || pc_a !== 32'h8000_0020) begin
      n_fail++; $display("FAIL arst_accept: flush=%b pc=%h want 1 80000020", flush_a, pc_a);
    end
    @(negedge clk); exc = 32'h0;
  endtask

  task automatic test_perf();
    logic [31:0] e_ps, e_pf;
    do_reset();
    stallreq = 6'b000100;
    repeat (5) @(negedge clk);
    stallreq = 6'h0;
    for (int k = 0; k < 2; k++) begin
      exc = EXC_TRAP; @(negedge clk);
      exc = 32'h0; repeat (3) @(negedge clk);
    end
    #1;
`ifdef PIPE_CTRL_PERF_EN
    e_ps = 32'd5; e_pf = 32'd2;
`else
    e_ps = 32'd0; e_pf = 32'd0;
`endif
    n_tests++;
    if (ps_a !== e_ps || pf_a !== e_pf) begin
      n_fail++; $display("FAIL perf_a: stall_cnt=%0d flush_cnt=%0d want %0d %0d", ps_a, pf_a, e_ps, e_pf);
    end
    n_tests++;
    if (ps_b !== e_ps || pf_b !== e_pf) begin
      n_fail++; $display("FAIL perf_b: stall_cnt=%0d flush_cnt=%0d want %0d %0d", ps_b, pf_b, e_ps, e_pf);
    end
  endtask

  task automatic test_random();
    int          fc [2] = '{3, 1};
    int          wd [2] = '{8, 0};
    int          left [2], w [2];
    logic [31:0] mpc [2], mps [2], mpf [2];
    logic        mhang [2];
    logic [31:0] codes [6] = '{EXC_INT, EXC_SYSCALL, EXC_INVAL, EXC_TRAP, EXC_OV, EXC_ERET};
    logic [5:0]  e_st [2], o_st;
    logic        e_fl, o_fl, o_hg;
    logic [31:0] e_pc, o_pc, o_ps, o_pf, tgt, x_ps, x_pf;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; w[i] = 0; mpc[i] = 32'h0; mps[i] = 32'h0; mpf[i] = 32'h0; mhang[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      stallreq = ($urandom_range(0, 3) == 0) ? 6'h0 : 6'($urandom);
      hold     = ($urandom_range(0, 7) == 0);
      exc      = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 5)] : 32'h0;
      epc      = $urandom;
      ebase    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      tgt      = (exc == EXC_ERET) ? epc : ebase + 32'h20;
      #1;
      for (int i = 0; i < 2; i++) begin
        e_fl    = (left[i] > 0) || (exc != 32'h0);
        e_pc    = (left[i] > 0) ? mpc[i] : ((exc != 32'h0) ? tgt : 32'h0);
        e_st[i] = e_fl ? 6'h0 : (hold ? 6'h3f : therm(stallreq));
`ifdef PIPE_CTRL_PERF_EN
        x_ps = mps[i]; x_pf = mpf[i];
`else
        x_ps = 32'h0; x_pf = 32'h0;
`endif
        o_st = (i == 0) ? stall_a : stall_b;
        o_fl = (i == 0) ? flush_a : flush_b;
        o_pc = (i == 0) ? pc_a : pc_b;
        o_hg = (i == 0) ? hang_a : hang_b;
        o_ps = (i == 0) ? ps_a : ps_b;
        o_pf = (i == 0) ? pf_a : pf_b;
        n_tests++;
        if (o_st !== e_st[i] || o_fl !== e_fl || (e_fl && o_pc !== e_pc) || o_hg !== mhang[i]
            || o_ps !== x_ps || o_pf !== x_pf) begin
          n_fail++;
          $display("FAIL rand_%0d_c%0d: st=%b fl=%b pc=%h hg=%b ps=%0d pf=%0d want %b %b %h %b %0d %0d",
                   i, cyc, o_st, o_fl, o_pc, o_hg, o_ps, o_pf, e_st[i], e_fl, e_pc, mhang[i], x_ps, x_pf);
        end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (left[i] > 0) left[i]--;
        else if (exc != 32'h0) begin mpc[i] = tgt; left[i] = fc[i] - 1; mpf[i]++; end
        if (e_st[i] != 6'h0) mps[i]++;
        if (wd[i] > 0) begin
          w[i] = (e_st[i] != 6'h0) ? ((w[i] < wd[i]) ? w[i] + 1 : wd[i]) : 0;
          if (w[i] == wd[i]) mhang[i] = 1'b1;
        end
      end
      @(negedge clk);
    end
    stallreq = 6'h0; hold = 1'b0; exc = 32'h0;
  endtask

  initial begin
    test_reset();
    test_stall_encode();
    test_exception();
    test_flush_seq();
    test_watchdog();
    test_async_reset();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
